// File: rtl/ac1c2_pkg.sv
// Shared types and constants for the A/C1/C2 <-> RGB colour-space converters.
// Pixel words carry a signed Q.13 value in bits [27:3]; coefficients are Q4.14.
package ac1c2_pkg;

    localparam int COEF_W    = 18;
    localparam int PIX_FRAC  = 13;
    localparam int COEF_FRAC = 14;
    localparam int X_MSB     = 27;
    localparam int X_LSB     = 3;
    localparam int X_W       = X_MSB - X_LSB + 1;
    localparam int RND_SHIFT = PIX_FRAC + COEF_FRAC;

    // Rows R,G,B; columns A,C1,C2. Inverse of the forward luma/opponent matrix.
    typedef logic [0:2][0:2][COEF_W-1:0] coef_mat_t;

    localparam coef_mat_t INV_COEF_DEF = '{
        '{18'sd16384,  18'sd0,     18'sd22970},
        '{18'sd16384, -18'sd5638, -18'sd11700},
        '{18'sd16384,  18'sd29032, 18'sd0}
    };

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_pix_t;

    function automatic logic signed [X_W-1:0] unpack_x(input logic [31:0] w);
        return $signed(w[X_MSB:X_LSB]);
    endfunction

endpackage

// File: rtl/ac1c2_to_rgb_if.sv
// Stream bus for the A/C1/C2 -> RGB converter: input triple, output pixel and debug stats.
interface ac1c2_to_rgb_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      i_A;
    logic [31:0]      i_C1;
    logic [31:0]      i_C2;
    logic             i_valid;
    logic             o_ready;
    logic [7:0]       o_R;
    logic [7:0]       o_G;
    logic [7:0]       o_B;
    logic             o_valid;
    logic             i_ready;
    logic             i_clr_stat;
    logic [CNT_W-1:0] o_sat_cnt;

    modport master (
        output i_A, i_C1, i_C2, i_valid, i_ready, i_clr_stat,
        input  o_ready, o_R, o_G, o_B, o_valid, o_sat_cnt
    );

    modport slave (
        input  i_A, i_C1, i_C2, i_valid, i_ready, i_clr_stat,
        output o_ready, o_R, o_G, o_B, o_valid, o_sat_cnt
    );
endinterface

// File: rtl/ac1c2_row_mac.sv
// One output channel: three registered products, then sum, round-half-up and clamp to 0..255.
module ac1c2_row_mac
    import ac1c2_pkg::*;
#(
    parameter int                 CW       = COEF_W,
    parameter logic [0:2][CW-1:0] ROW_COEF = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 adv,
    input  logic                 s1_valid,
    input  logic                 s2_valid,
    input  logic signed [X_W-1:0] x_a,
    input  logic signed [X_W-1:0] x_c1,
    input  logic signed [X_W-1:0] x_c2,
    output logic [7:0]           pix,
    output logic                 sat
);
    localparam int PW = X_W + CW;
    localparam int SW = PW + 2;
    localparam int TW = SW - RND_SHIFT;
    localparam logic signed [SW-1:0] HALF_C =
        {{(SW - RND_SHIFT){1'b0}}, 1'b1, {(RND_SHIFT - 1){1'b0}}};

    logic signed [X_W-1:0] x_s [3];
    logic signed [PW-1:0]  prod_r [3];
    logic signed [SW-1:0]  sum_s;
    logic signed [SW-1:0]  rnd_s;
    logic [TW-1:0]         t_s;
    logic [7:0]            pix_s;
    logic                  clamp_s;
    logic [7:0]            pix_r;

    // Column operands in coefficient order A, C1, C2.
    always_comb begin
        x_s[0] = x_a;
        x_s[1] = x_c1;
        x_s[2] = x_c2;
    end

    // Stage 2: products load only for valid beats so bubbles do not toggle the multipliers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int c = 0; c < 3; c++) prod_r[c] <= '0;
        end else if (adv && s1_valid) begin
            for (int c = 0; c < 3; c++)
                prod_r[c] <= $signed(PW'(x_s[c])) * $signed(PW'($signed(ROW_COEF[c])));
        end
    end

    // Sum in Q.27, add half an LSB, keep the integer part, then clamp.
    always_comb begin
        sum_s = SW'(prod_r[0]) + SW'(prod_r[1]) + SW'(prod_r[2]);
        rnd_s = sum_s + HALF_C;
        t_s   = rnd_s[SW-1:RND_SHIFT];
        if (t_s[TW-1]) begin
            pix_s   = 8'd0;
            clamp_s = 1'b1;
        end else if (|t_s[TW-2:8]) begin
            pix_s   = 8'd255;
            clamp_s = 1'b1;
        end else begin
            pix_s   = t_s[7:0];
            clamp_s = 1'b0;
        end
    end

    // Stage 3: output pixel register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pix_r <= 8'd0;
        end else if (adv && s2_valid) begin
            pix_r <= pix_s;
        end
    end

    assign pix = pix_r;
    assign sat = clamp_s;

endmodule

// File: rtl/ac1c2_to_rgb.sv
// A/C1/C2 -> 8-bit RGB: unpack, 3x3 inverse matrix, round/clamp, under a global-stall handshake.
// Also keeps a sticky, non-wrapping count of clamped output channels for debug.
module ac1c2_to_rgb #(
    parameter int                            COEF_W   = ac1c2_pkg::COEF_W,
    parameter logic [0:2][0:2][COEF_W-1:0]   INV_COEF = ac1c2_pkg::INV_COEF_DEF,
    parameter int                            CNT_W    = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    ac1c2_to_rgb_if.slave      bus
);
    import ac1c2_pkg::*;

    logic                  adv_s;
    logic                  v1_r;
    logic                  v2_r;
    logic                  v3_r;
    logic signed [X_W-1:0] xa_r;
    logic signed [X_W-1:0] xc1_r;
    logic signed [X_W-1:0] xc2_r;
    logic [7:0]            pix_s [3];
    logic [2:0]            clamp_s;
    rgb_pix_t              out_s;
    logic [1:0]            n_clamp_s;
    logic [CNT_W:0]        cnt_sum_s;
    logic [CNT_W-1:0]      cnt_next_s;
    logic [CNT_W-1:0]      sat_cnt_r;
    logic                  unused_bits_s;

    // Whole pipeline moves together whenever the output slot is free or being drained.
    assign adv_s       = !v3_r || bus.i_ready;
    assign bus.o_ready = adv_s;
    assign bus.o_valid = v3_r;

    // Stage valids shift with the pipeline so bubbles travel through.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            v3_r <= 1'b0;
        end else if (adv_s) begin
            v1_r <= bus.i_valid;
            v2_r <= v1_r;
            v3_r <= v2_r;
        end
    end

    // Stage 1: unpack the three signed operands on an accepted beat.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            xa_r  <= '0;
            xc1_r <= '0;
            xc2_r <= '0;
        end else if (adv_s && bus.i_valid) begin
            xa_r  <= unpack_x(bus.i_A);
            xc1_r <= unpack_x(bus.i_C1);
            xc2_r <= unpack_x(bus.i_C2);
        end
    end

    for (genvar r = 0; r < 3; r++) begin : g_row
        ac1c2_row_mac #(
            .CW       (COEF_W),
            .ROW_COEF (INV_COEF[r])
        ) u_row (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .adv      (adv_s),
            .s1_valid (v1_r),
            .s2_valid (v2_r),
            .x_a      (xa_r),
            .x_c1     (xc1_r),
            .x_c2     (xc2_r),
            .pix      (pix_s[r]),
            .sat      (clamp_s[r])
        );
    end

    assign out_s     = '{r: pix_s[0], g: pix_s[1], b: pix_s[2]};
    assign bus.o_R   = out_s.r;
    assign bus.o_G   = out_s.g;
    assign bus.o_B   = out_s.b;

    // Next counter value: add this beat's clamped channels, pinned at all-ones.
    always_comb begin
        n_clamp_s = {1'b0, clamp_s[0]} + {1'b0, clamp_s[1]} + {1'b0, clamp_s[2]};
        cnt_sum_s = {1'b0, sat_cnt_r} + {{(CNT_W - 1){1'b0}}, n_clamp_s};
        if (cnt_sum_s[CNT_W]) begin
            cnt_next_s = '1;
        end else begin
            cnt_next_s = cnt_sum_s[CNT_W-1:0];
        end
    end

    // Saturation counter; a clear wins over an increment in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sat_cnt_r <= '0;
        end else if (bus.i_clr_stat) begin
            sat_cnt_r <= '0;
        end else if (adv_s && v2_r) begin
            sat_cnt_r <= cnt_next_s;
        end
    end

    assign bus.o_sat_cnt = sat_cnt_r;

    assign unused_bits_s = ^{bus.i_A[31:28],  bus.i_A[2:0],
                             bus.i_C1[31:28], bus.i_C1[2:0],
                             bus.i_C2[31:28], bus.i_C2[2:0]};

endmodule

// File: tb/tb_ac1c2_to_rgb.sv
// Directed bench for ac1c2_to_rgb: identity-matrix instance for exact values, default-matrix
// instance for the RGB -> A/C1/C2 -> RGB round trip.
module tb_ac1c2_to_rgb;
    import ac1c2_pkg::*;

    localparam coef_mat_t ID_COEF = '{
        '{18'sd16384, 18'sd0,     18'sd0},
        '{18'sd0,     18'sd16384, 18'sd0},
        '{18'sd0,     18'sd0,     18'sd16384}
    };

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   er [10];
    int   eg [10];
    int   eb [10];
    int   sent;
    int   recv;

    always #5 clk = ~clk;

    ac1c2_to_rgb_if #(.CNT_W(16)) bi ();
    ac1c2_to_rgb_if #(.CNT_W(16)) bd ();

    ac1c2_to_rgb #(.COEF_W(18), .INV_COEF(ID_COEF), .CNT_W(16)) dut_id (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bi.slave)
    );

    ac1c2_to_rgb dut_def (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bd.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp);
        total++;
        assert ((obs - exp) <= 1 && (obs - exp) >= -1) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d (+/-1)", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] pack_x(input int x);
        logic [24:0] f;
        f = x[24:0];
        return {4'h0, f, 3'h0};
    endfunction

    function automatic logic [31:0] pix_word(input int p);
        return pack_x(p * 8192);
    endfunction

    // Forward converter model: Q4.14 coefficients, result rounded to Q.13.
    function automatic int fwd(input int r, input int g, input int b,
                               input int k0, input int k1, input int k2);
        int s;
        s = r * k0 + g * k1 + b * k2;
        return (s + 1) >>> 1;
    endfunction

    task automatic send_id(input string tag, input logic [31:0] a, input logic [31:0] c1,
                           input logic [31:0] c2, input logic clr,
                           input int xr, input int xg, input int xb, input int xcnt);
        bi.i_A     = a;
        bi.i_C1    = c1;
        bi.i_C2    = c2;
        bi.i_valid = 1'b1;
        #1;
        check({tag, "_rdy"}, 32'(bi.o_ready), 32'd1);
        tick();
        bi.i_valid = 1'b0;
        check({tag, "_v1"}, 32'(bi.o_valid), 32'd0);
        tick();
        check({tag, "_v2"}, 32'(bi.o_valid), 32'd0);
        bi.i_clr_stat = clr;
        tick();
        bi.i_clr_stat = 1'b0;
        check({tag, "_v3"}, 32'(bi.o_valid), 32'd1);
        check({tag, "_r"}, 32'(bi.o_R), 32'(xr));
        check({tag, "_g"}, 32'(bi.o_G), 32'(xg));
        check({tag, "_b"}, 32'(bi.o_B), 32'(xb));
        check({tag, "_cnt"}, 32'(bi.o_sat_cnt), 32'(xcnt));
    endtask

    task automatic round_trip(input string tag, input int r, input int g, input int b);
        bd.i_A     = pack_x(fwd(r, g, b, 4899, 9617, 1868));
        bd.i_C1    = pack_x(fwd(r, g, b, -2765, -5427, 8192));
        bd.i_C2    = pack_x(fwd(r, g, b, 8192, -6860, -1332));
        bd.i_valid = 1'b1;
        tick();
        bd.i_valid = 1'b0;
        tick();
        tick();
        check({tag, "_v"}, 32'(bd.o_valid), 32'd1);
        check_near({tag, "_r"}, int'(bd.o_R), r);
        check_near({tag, "_g"}, int'(bd.o_G), g);
        check_near({tag, "_b"}, int'(bd.o_B), b);
    endtask

    initial begin
        rst = 1'b1;
        bi.i_A = 32'h0; bi.i_C1 = 32'h0; bi.i_C2 = 32'h0;
        bi.i_valid = 1'b0; bi.i_ready = 1'b1; bi.i_clr_stat = 1'b0;
        bd.i_A = 32'h0; bd.i_C1 = 32'h0; bd.i_C2 = 32'h0;
        bd.i_valid = 1'b0; bd.i_ready = 1'b1; bd.i_clr_stat = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(bi.o_valid), 32'd0);
        check("rst_r", 32'(bi.o_R), 32'd0);
        check("rst_cnt", 32'(bi.o_sat_cnt), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_ready", 32'(bi.o_ready), 32'd1);

        send_id("basic", 32'h0064_0000, 32'h0032_0000, 32'h00C8_0000, 1'b0, 100, 50, 200, 0);
        send_id("neg_g", 32'h0064_0000, 32'h0FFB_0000, 32'h0000_0000, 1'b0, 100, 0, 0, 1);
        send_id("big_r", pix_word(300), 32'h0, 32'h0, 1'b0, 255, 0, 0, 2);
        send_id("rnd_dn", pack_x(100 * 8192 + 4095), 32'h0, 32'h0, 1'b0, 100, 0, 0, 2);
        send_id("rnd_up", pack_x(100 * 8192 + 4096), 32'h0, 32'h0, 1'b0, 101, 0, 0, 2);
        send_id("clr", pack_x(-8192), 32'h0, 32'h0, 1'b1, 0, 0, 0, 0);
        tick();
        check("clr_hold", 32'(bi.o_sat_cnt), 32'd0);

        // Back-pressure: i_ready follows 1,0,0,1 while ten beats stream in.
        for (int k = 0; k < 10; k++) begin
            er[k] = k * 25 + 3;
            eg[k] = 250 - k * 20;
            eb[k] = (k * 37) % 256;
        end
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 80 && recv < 10; cyc++) begin
            bi.i_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if (sent < 10) begin
                bi.i_A     = pix_word(er[sent]);
                bi.i_C1    = pix_word(eg[sent]);
                bi.i_C2    = pix_word(eb[sent]);
                bi.i_valid = 1'b1;
            end else begin
                bi.i_valid = 1'b0;
            end
            #1;
            if (bi.o_valid) begin
                check("bp_r", 32'(bi.o_R), 32'(er[recv]));
                check("bp_g", 32'(bi.o_G), 32'(eg[recv]));
                check("bp_b", 32'(bi.o_B), 32'(eb[recv]));
                if (bi.i_ready) recv++;
            end
            if (bi.i_valid && bi.o_ready) sent++;
            tick();
        end
        bi.i_valid = 1'b0;
        bi.i_ready = 1'b1;
        check("bp_count", 32'(recv), 32'd10);
        check("bp_drain", 32'(bi.o_valid), 32'd0);

        // Reset with three clamping beats in flight.
        bi.i_ready = 1'b0;
        bi.i_A     = pack_x(-8192);
        bi.i_C1    = 32'h0;
        bi.i_C2    = 32'h0;
        bi.i_valid = 1'b1;
        tick();
        tick();
        tick();
        bi.i_valid = 1'b0;
        #1;
        check("mid_pre_v", 32'(bi.o_valid), 32'd1);
        check("mid_pre_rdy", 32'(bi.o_ready), 32'd0);
        check("mid_pre_cnt", 32'(bi.o_sat_cnt), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_v", 32'(bi.o_valid), 32'd0);
        check("mid_rst_cnt", 32'(bi.o_sat_cnt), 32'd0);
        tick();
        rst = 1'b0;
        bi.i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mid_flush", 32'(bi.o_valid), 32'd0);
        end

        round_trip("rt_red", 255, 0, 0);
        round_trip("rt_grn", 0, 255, 0);
        round_trip("rt_blu", 0, 0, 255);
        round_trip("rt_wht", 255, 255, 255);
        round_trip("rt_blk", 0, 0, 0);
        round_trip("rt_mix", 12, 200, 77);
        for (int i = 0; i < 4; i++) begin
            round_trip("rt_rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
